// File: rtl/aes128_core_sequencer.sv
// AXI4-Lite register front-end and job sequencer for the AES-128 encrypt core.
// Holds key/plaintext/ciphertext registers and steps the core through one job per START.
module aes128_core_sequencer #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6,
   parameter int TIMEOUT_CYCLES     = 64
) (
   input  logic                              S_AXI_ACLK,
   input  logic                              S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic [127:0]                      core_key,
   output logic [127:0]                      core_din,
   output logic                              core_start,
   input  logic                              core_done,
   input  logic [127:0]                      core_dout,
   output logic                              irq
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_CAPTURE} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              awready_q, awready_d;
   logic              bvalid_q, bvalid_d;
   logic              arready_q, arready_d;
   logic              rvalid_q, rvalid_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              irq_en_q, irq_en_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              core_start_q, core_start_d;
   logic [3:0][31:0]  key_q, key_d;
   logic [3:0][31:0]  pt_q, pt_d;
   logic [3:0][31:0]  ct_q, ct_d;
   logic [127:0]      core_key_q, core_key_d;
   logic [127:0]      core_din_q, core_din_d;

   logic              wr_en, rd_en, wr_hit, busy, start_req;
   logic [3:0]        wr_word;
   logic [31:0]       rd_mux;
   logic [3:0]        key_we, pt_we;

   // A write only lands on the cycle AWREADY/WREADY are shown; misaligned addresses hit nothing.
   assign wr_en     = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
   assign rd_en     = arready_q & S_AXI_ARVALID;
   assign wr_hit    = wr_en & (S_AXI_AWADDR[1:0] == 2'b00);
   assign wr_word   = S_AXI_AWADDR[5:2];
   assign busy      = (state_q != S_IDLE);
   assign start_req = wr_hit & (wr_word == 4'h0) & S_AXI_WSTRB[0] & S_AXI_WDATA[0];

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_we
         assign key_we[gi] = wr_hit & (wr_word == 4'(4 + gi));
         assign pt_we[gi]  = wr_hit & (wr_word == 4'(8 + gi));
      end
   endgenerate

   always_comb begin
      rd_mux = 32'h0;
      if (S_AXI_ARADDR[1:0] == 2'b00) begin
         case (S_AXI_ARADDR[5:2])
            4'h0:                    rd_mux = {30'h0, irq_en_q, 1'b0};
            4'h1:                    rd_mux = {29'h0, err_q, done_q, busy};
            4'h4, 4'h5, 4'h6, 4'h7:  rd_mux = key_q[S_AXI_ARADDR[3:2]];
            4'h8, 4'h9, 4'hA, 4'hB:  rd_mux = pt_q[S_AXI_ARADDR[3:2]];
            4'hC, 4'hD, 4'hE, 4'hF:  rd_mux = ct_q[S_AXI_ARADDR[3:2]];
            default:                 rd_mux = 32'h0;
         endcase
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      irq_en_d     = irq_en_q;
      done_d       = done_q;
      err_d        = err_q;
      key_d        = key_q;
      pt_d         = pt_q;
      ct_d         = ct_q;
      core_key_d   = core_key_q;
      core_din_d   = core_din_q;
      core_start_d = 1'b0;

      awready_d = ~awready_q & ~bvalid_q & S_AXI_AWVALID & S_AXI_WVALID;
      bvalid_d  = wr_en ? 1'b1 : (bvalid_q & ~S_AXI_BREADY);
      arready_d = ~arready_q & ~rvalid_q & S_AXI_ARVALID;
      rvalid_d  = rd_en ? 1'b1 : (rvalid_q & ~S_AXI_RREADY);
      rdata_d   = rd_en ? rd_mux : rdata_q;

      if (wr_hit && wr_word == 4'h0 && S_AXI_WSTRB[0]) irq_en_d = S_AXI_WDATA[1];
      if (wr_hit && wr_word == 4'h1 && S_AXI_WSTRB[0]) begin
         if (S_AXI_WDATA[1]) done_d = 1'b0;
         if (S_AXI_WDATA[2]) err_d  = 1'b0;
      end
      for (int w = 0; w < 4; w++) begin
         for (int b = 0; b < 4; b++) begin
            if (key_we[w] && S_AXI_WSTRB[b]) key_d[w][b*8 +: 8] = S_AXI_WDATA[b*8 +: 8];
            if (pt_we[w]  && S_AXI_WSTRB[b]) pt_d[w][b*8 +: 8]  = S_AXI_WDATA[b*8 +: 8];
         end
      end

      // Sequencer updates come after the W1C decode so a same-cycle set of DONE/ERR wins.
      case (state_q)
         S_IDLE: begin
            if (start_req) begin
               state_d      = S_LOAD;
               core_key_d   = key_q;
               core_din_d   = pt_q;
               core_start_d = 1'b1;
            end
         end
         S_LOAD: begin
            cnt_d   = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (core_done) begin
               ct_d    = core_dout;
               state_d = S_CAPTURE;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_CAPTURE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         awready_q    <= 1'b0;
         bvalid_q     <= 1'b0;
         arready_q    <= 1'b0;
         rvalid_q     <= 1'b0;
         rdata_q      <= 32'h0;
         irq_en_q     <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         core_start_q <= 1'b0;
         key_q        <= '0;
         pt_q         <= '0;
         ct_q         <= '0;
         core_key_q   <= '0;
         core_din_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         awready_q    <= awready_d;
         bvalid_q     <= bvalid_d;
         arready_q    <= arready_d;
         rvalid_q     <= rvalid_d;
         rdata_q      <= rdata_d;
         irq_en_q     <= irq_en_d;
         done_q       <= done_d;
         err_q        <= err_d;
         core_start_q <= core_start_d;
         key_q        <= key_d;
         pt_q         <= pt_d;
         ct_q         <= ct_d;
         core_key_q   <= core_key_d;
         core_din_q   <= core_din_d;
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = awready_q;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = 2'b00;
   assign S_AXI_RVALID  = rvalid_q;
   assign core_key      = core_key_q;
   assign core_din      = core_din_q;
   assign core_start    = core_start_q;
   assign irq           = done_q & irq_en_q;

endmodule

// File: tb/tb_aes128_core_sequencer.sv
// Directed bench for the AES-128 sequencer: AXI-Lite master tasks plus a
// behavioural core that answers core_start with core_done after a set latency.
module tb_aes128_core_sequencer;

   logic         clk = 1'b0;
   logic         aresetn;
   logic [5:0]   awaddr, araddr;
   logic         awvalid, wvalid, bready, arvalid, rready;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;
   logic         awready, wready, bvalid, arready, rvalid;
   logic [1:0]   bresp, rresp;
   logic [31:0]  rdata;
   logic [127:0] core_key, core_din, core_dout;
   logic         core_start, core_done, irq;

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;
   bit model_en = 1'b1;
   int model_lat = 2;
   logic [127:0] model_ct = 128'h0;
   logic start_after_hs, irq_after_hs;

   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   always #5 clk = ~clk;

   aes128_core_sequencer dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(aresetn),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .core_key(core_key), .core_din(core_din), .core_start(core_start),
      .core_done(core_done), .core_dout(core_dout), .irq(irq)
   );

   always @(negedge clk) if (core_start === 1'b1) start_cnt++;

   // Outside the done cycle core_dout carries the inverse so a late capture is visible.
   initial begin
      core_done = 1'b0;
      core_dout = '0;
      forever begin
         @(negedge clk);
         core_done = 1'b0;
         core_dout = ~model_ct;
         if (core_start === 1'b1 && model_en) begin
            repeat (model_lat) @(negedge clk);
            core_done = 1'b1;
            core_dout = model_ct;
         end
      end
   end

   task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
      bit ok = 1'b0;
      @(negedge clk);
      awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (awready && wready) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL wr_ready addr=%h got AWREADY=0 required 1", addr); end
      @(posedge clk); #1;
      start_after_hs = core_start;
      irq_after_hs   = irq;
      awvalid = 1'b0; wvalid = 1'b0;
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
         if (bvalid) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (!ok || bresp !== 2'b00) begin
         errors++; $display("FAIL wr_resp addr=%h got BVALID=%b BRESP=%b required 1/00", addr, ok, bresp);
      end
      @(posedge clk); #1;
   endtask

   task automatic axi_read(input logic [5:0] addr, output logic [31:0] data);
      bit ok = 1'b0;
      data = 32'hx;
      @(negedge clk);
      araddr = addr; arvalid = 1'b1;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (arready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      arvalid = 1'b0;
      if (ok) begin
         ok = 1'b0;
         for (int t = 0; t < 20; t++) begin
            if (rvalid) begin ok = 1'b1; data = rdata; break; end
            @(negedge clk);
         end
      end
      checks++;
      if (!ok || rresp !== 2'b00) begin
         errors++; $display("FAIL rd_handshake addr=%h got RVALID=%b RRESP=%b required 1/00", addr, ok, rresp);
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_idle(output logic [31:0] st);
      bit ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         axi_read(6'h04, st);
         if (st[0] == 1'b0) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL wait_idle got BUSY=1 required BUSY=0"); end
   endtask

   task automatic test_reset;
      logic [31:0] v;
      aresetn = 1'b0;
      awaddr = '0; wdata = '0; wstrb = '0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
      araddr = '0; arvalid = 1'b0; rready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      aresetn = 1'b1;
      @(negedge clk);
      checks++;
      if ({awready, wready, bvalid, arready, rvalid, core_start, irq} !== 7'b0) begin
         errors++; $display("FAIL reset_outputs got %b required 0000000",
                            {awready, wready, bvalid, arready, rvalid, core_start, irq});
      end
      checks++;
      if (core_key !== 128'h0 || core_din !== 128'h0) begin
         errors++; $display("FAIL reset_operands got key=%h din=%h required 0", core_key, core_din);
      end
      axi_read(6'h00, v); checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h required 0", v); end
      axi_read(6'h04, v); checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL reset_status got %h required 0", v); end
      axi_read(6'h3C, v); checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL reset_ct3 got %h required 0", v); end
   endtask

   task automatic test_fips;
      logic [31:0] v;
      int s0;
      logic [31:0] exp_ct [4];
      exp_ct[0] = 32'h70b4c55a; exp_ct[1] = 32'hd8cdb780; exp_ct[2] = 32'h6a7b0430; exp_ct[3] = 32'h69c4e0d8;
      model_en = 1'b1; model_lat = 2; model_ct = FIPS_CT;
      axi_write(6'h10, 32'h0c0d0e0f, 4'hF); axi_write(6'h14, 32'h08090a0b, 4'hF);
      axi_write(6'h18, 32'h04050607, 4'hF); axi_write(6'h1C, 32'h00010203, 4'hF);
      axi_write(6'h20, 32'hccddeeff, 4'hF); axi_write(6'h24, 32'h8899aabb, 4'hF);
      axi_write(6'h28, 32'h44556677, 4'hF); axi_write(6'h2C, 32'h00112233, 4'hF);
      s0 = start_cnt;
      axi_write(6'h00, 32'h1, 4'hF);
      checks++;
      if (start_after_hs !== 1'b1) begin
         errors++; $display("FAIL start_latency got core_start=%b required 1", start_after_hs);
      end
      checks++;
      if (core_key !== FIPS_KEY || core_din !== FIPS_PT) begin
         errors++; $display("FAIL fips_operands got key=%h din=%h required %h %h", core_key, core_din, FIPS_KEY, FIPS_PT);
      end
      wait_idle(v);
      checks++;
      if (v !== 32'h2) begin errors++; $display("FAIL fips_status got %h required 2", v); end
      for (int w = 0; w < 4; w++) begin
         axi_read(6'(6'h30 + 4 * w), v);
         checks++;
         if (v !== exp_ct[w]) begin errors++; $display("FAIL fips_ct%0d got %h required %h", w, v, exp_ct[w]); end
      end
      checks++;
      if (start_cnt - s0 !== 1) begin errors++; $display("FAIL fips_start_pulses got %0d required 1", start_cnt - s0); end
      axi_read(6'h00, v); checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL ctrl_start_reads0 got %h required 0", v); end
   endtask

   task automatic test_irq;
      logic [31:0] v;
      axi_write(6'h04, 32'h2, 4'hF);
      axi_write(6'h00, 32'h2, 4'hF);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %b required 0", irq); end
      axi_write(6'h00, 32'h3, 4'hF);
      wait_idle(v);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b required 1", irq); end
      axi_write(6'h04, 32'h2, 4'hF);
      checks++;
      if (irq_after_hs !== 1'b0) begin errors++; $display("FAIL irq_clear got %b required 0", irq_after_hs); end
      axi_read(6'h04, v); checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL irq_status got %h required 0", v); end
      axi_read(6'h00, v); checks++;
      if (v !== 32'h2) begin errors++; $display("FAIL irq_en_readback got %h required 2", v); end
   endtask

   task automatic test_timeout;
      logic [31:0] v;
      axi_write(6'h00, 32'h0, 4'hF);
      model_en = 1'b0;
      axi_write(6'h00, 32'h1, 4'hF);
      repeat (30) @(negedge clk);
      axi_read(6'h04, v); checks++;
      if (v !== 32'h1) begin errors++; $display("FAIL timeout_busy got %h required 1", v); end
      repeat (40) @(negedge clk);
      axi_read(6'h04, v); checks++;
      if (v !== 32'h4) begin errors++; $display("FAIL timeout_err got %h required 4", v); end
      axi_read(6'h30, v); checks++;
      if (v !== 32'h70b4c55a) begin errors++; $display("FAIL timeout_ct got %h required 70b4c55a", v); end
      axi_write(6'h04, 32'h4, 4'hF);
      axi_read(6'h04, v); checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL err_w1c got %h required 0", v); end
      model_en = 1'b1;
   endtask

   task automatic test_start_during_run;
      logic [31:0] v;
      int s0;
      model_lat = 20; model_ct = 128'h0123456789abcdef_fedcba9876543210;
      s0 = start_cnt;
      axi_write(6'h00, 32'h1, 4'hF);
      axi_write(6'h10, 32'hdeadbeef, 4'hF);
      axi_write(6'h00, 32'h1, 4'hF);
      checks++;
      if (core_key !== FIPS_KEY) begin errors++; $display("FAIL busy_key_hold got %h required %h", core_key, FIPS_KEY); end
      wait_idle(v);
      checks++;
      if (start_cnt - s0 !== 1) begin errors++; $display("FAIL restart_pulses got %0d required 1", start_cnt - s0); end
      checks++;
      if (v !== 32'h2) begin errors++; $display("FAIL restart_status got %h required 2", v); end
      axi_read(6'h30, v); checks++;
      if (v !== 32'h76543210) begin errors++; $display("FAIL restart_ct0 got %h required 76543210", v); end
      axi_read(6'h10, v); checks++;
      if (v !== 32'hdeadbeef) begin errors++; $display("FAIL busy_key_write got %h required deadbeef", v); end
      axi_write(6'h04, 32'h2, 4'hF);
   endtask

   task automatic test_wstrb;
      logic [31:0] v;
      axi_write(6'h10, 32'h0, 4'hF);
      axi_write(6'h10, 32'hAABBCCDD, 4'b0001);
      axi_read(6'h10, v); checks++;
      if (v !== 32'h000000DD) begin errors++; $display("FAIL wstrb_lane0 got %h required 000000dd", v); end
      axi_write(6'h10, 32'h11223344, 4'b1100);
      axi_read(6'h10, v); checks++;
      if (v !== 32'h112200DD) begin errors++; $display("FAIL wstrb_upper got %h required 112200dd", v); end
      axi_write(6'h34, 32'h55555555, 4'hF);
      axi_read(6'h34, v); checks++;
      if (v !== 32'hd8cdb780 && v !== 32'hfedcba98) begin
         errors++; $display("FAIL ct_readonly got %h required fedcba98", v);
      end
   endtask

   task automatic test_reset_mid_job;
      logic [31:0] v;
      int s0;
      model_lat = 40; model_ct = FIPS_CT;
      axi_write(6'h18, 32'h5a5a5a5a, 4'hF);
      axi_write(6'h00, 32'h1, 4'hF);
      repeat (5) @(negedge clk);
      aresetn = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (core_key !== 128'h0 || core_din !== 128'h0 || core_start !== 1'b0 || bvalid !== 1'b0 || rvalid !== 1'b0) begin
         errors++; $display("FAIL midjob_reset got key=%h din=%h start=%b required 0", core_key, core_din, core_start);
      end
      aresetn = 1'b1;
      repeat (50) @(negedge clk);
      axi_read(6'h04, v); checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL midjob_status got %h required 0", v); end
      axi_read(6'h18, v); checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL midjob_key2 got %h required 0", v); end
      axi_read(6'h30, v); checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL midjob_ct0 got %h required 0", v); end
      model_lat = 2;
      s0 = start_cnt;
      axi_write(6'h00, 32'h1, 4'hF);
      wait_idle(v);
      checks++;
      if (v !== 32'h2 || start_cnt - s0 !== 1) begin
         errors++; $display("FAIL postreset_job got status=%h pulses=%0d required 2/1", v, start_cnt - s0);
      end
      axi_read(6'h3C, v); checks++;
      if (v !== 32'h69c4e0d8) begin errors++; $display("FAIL postreset_ct3 got %h required 69c4e0d8", v); end
   endtask

   task automatic test_stall;
      bit ok = 1'b0;
      @(negedge clk);
      bready = 1'b0;
      awaddr = 6'h14; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (awready) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL stall_awready got 0 required 1"); end
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            errors++; $display("FAIL bvalid_hold cycle %0d got %b/%b required 1/00", c, bvalid, bresp);
         end
      end
      bready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bvalid !== 1'b0) begin errors++; $display("FAIL bvalid_drop got %b required 0", bvalid); end
      @(negedge clk);
      rready = 1'b0;
      araddr = 6'h14; arvalid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (arready) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL stall_arready got 0 required 1"); end
      @(posedge clk); #1;
      arvalid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (rvalid !== 1'b1 || rdata !== 32'h12345678) begin
            errors++; $display("FAIL rvalid_hold cycle %0d got %b/%h required 1/12345678", c, rvalid, rdata);
         end
      end
      rready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_drop got %b required 0", rvalid); end
   endtask

   initial begin
      test_reset;
      test_fips;
      test_irq;
      test_timeout;
      test_start_during_run;
      test_wstrb;
      test_reset_mid_job;
      test_stall;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got no finish required finish");
      $fatal(1, "timeout");
   end

endmodule
